// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with centre-of-bit sampling.
// The bit period is cfg_div_i + 1 clocks, which is the same divisor the
// transmit side uses. Each good byte is presented with a one-cycle o_valid
// pulse. A low stop bit gives a one-cycle o_frame_err pulse instead.
module uart_rx #(
    parameter int Counter_Width = 16,
    parameter int DATA_BITS     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_en_i,
    input  logic [Counter_Width-1:0] cfg_div_i,
    input  logic                     rx_i,
    output logic [DATA_BITS-1:0]     o_data,
    output logic                     o_valid,
    output logic                     o_frame_err,
    output logic                     o_busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                   state_q, state_d;
    logic [Counter_Width-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
    logic [Counter_Width-1:0] div_q, div_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic                     valid_d;
    logic                     ferr_d;

    logic                     rx_m;
    logic                     rx_s;
    logic                     rx_s_d;

    logic [Counter_Width-1:0] half_div;
    logic                     cnt_hit;

    assign half_div = div_q >> 1;
    assign cnt_hit  = (cnt_q == div_q);
    assign o_busy   = (state_q != IDLE);

    // Two-flop synchronizer plus one delay stage for falling-edge detection; idle-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx_i;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    // Next-state, counter, bit index, shift and pulse decisions for the receive FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        div_d     = div_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                // Only a fresh falling edge starts a frame; a line that is already low does not.
                if (rx_s_d && !rx_s) begin
                    div_d   = cfg_div_i;
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == half_div) begin
                    cnt_d   = '0;
                    // If the line is high again at mid-start, the low was a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_hit) begin
                    cnt_d     = '0;
                    // LSB arrives first, so shift in at the MSB end.
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_hit) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_HIGH: begin
                cnt_d = '0;
                // Break or stuck-low line: wait for it to return high before re-arming.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable aborts any frame silently.
        if (!rx_en_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
            valid_d   = 1'b0;
            ferr_d    = 1'b0;
        end
    end

    // Control state, counters and output pulses; all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_data      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            o_valid     <= valid_d;
            o_frame_err <= ferr_d;
            if (valid_d) begin
                o_data <= shift_q;
            end
        end
    end

    // Latched divisor and shift register; both are always rewritten before use, so no reset is needed.
    always_ff @(posedge clk_i) begin
        div_q   <= div_d;
        shift_q <= shift_d;
    end

endmodule
